// File: rtl/parity_frame_checker.sv
// Serial receive-side parity checker.
// Collects DATA_W data bits (LSB first) followed by one parity bit, checks
// them against the even/odd rule latched at start of frame, and publishes a
// registered data word, pass/fail flags and a saturating error count.
module parity_frame_checker #(
    parameter int DATA_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              sof,
    input  logic              mode,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_done,
    output logic              parity_ok,
    output logic              parity_err,
    output logic [CNT_W-1:0]  err_count,
    output logic              busy
);

    // Bit counter must be able to hold DATA_W itself.
    localparam int CW = (DATA_W < 2) ? 1 : $clog2(DATA_W + 1);
    localparam logic [CW-1:0]    LAST_IDX = CW'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic [CW-1:0]     r_cnt;
    logic              r_mode;
    logic [DATA_W-1:0] r_data_out;
    logic              r_frame_done;
    logic              r_parity_ok;
    logic              r_parity_err;
    logic [CNT_W-1:0]  r_err_count;

    logic [DATA_W-1:0] w_first;
    logic [DATA_W-1:0] w_shift_ins;
    logic              w_pass;
    logic              w_fail;

    // Next shift-register contents: fresh frame word and in-frame insertion.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_first     = '0;
        w_first[0]  = bit_in;
        w_shift_ins = r_shift;
        for (int i = 0; i < DATA_W; i++) begin
            if (r_cnt == CW'(i)) begin
                w_shift_ins[i] = bit_in;
            end
        end
    end

    // Parity verdict for the bit currently offered as the parity bit.
    assign w_pass = ((^r_shift) ^ bit_in) == r_mode;
    assign w_fail = bit_valid && !sof && (r_state == S_PARITY) && !w_pass;

    // Frame FSM with registered results and saturating error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shift register is cleared too; it is a handful of flops, not a RAM.
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_mode       <= 1'b0;
            r_data_out   <= '0;
            r_frame_done <= 1'b0;
            r_parity_ok  <= 1'b0;
            r_parity_err <= 1'b0;
            r_err_count  <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
            r_frame_done <= 1'b0;

            if (w_fail) begin
                if (err_clr) begin
                    r_err_count <= CNT_W'(1);
                end else if (r_err_count != CNT_MAX) begin
                    r_err_count <= r_err_count + 1'b1;
                end
            end else if (err_clr) begin
                r_err_count <= '0;
            end

            if (bit_valid) begin
                if (sof) begin
                    // Start (or restart) a frame from any state.
                    r_mode  <= mode;
                    r_shift <= w_first;
                    r_cnt   <= CW'(1);
                    r_state <= (DATA_W == 1) ? S_PARITY : S_DATA;
                end else begin
                    case (r_state)
                        S_DATA: begin
                            r_shift <= w_shift_ins;
                            r_cnt   <= r_cnt + 1'b1;
                            if (r_cnt == LAST_IDX) begin
                                r_state <= S_PARITY;
                            end
                        end
                        S_PARITY: begin
                            r_data_out   <= r_shift;
                            r_parity_ok  <= w_pass;
                            r_parity_err <= !w_pass;
                            r_frame_done <= 1'b1;
                            r_cnt        <= '0;
                            r_state      <= S_IDLE;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign data_out   = r_data_out;
    assign frame_done = r_frame_done;
    assign parity_ok  = r_parity_ok;
    assign parity_err = r_parity_err;
    assign err_count  = r_err_count;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker: directed scenarios plus a random stream,
// all checked against a frame-level reference model (bit queue + popcount).
module tb_parity_frame_checker;

    localparam int DATA_W  = 3;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              bit_valid;
    logic              bit_in;
    logic              sof;
    logic              mode;
    logic              err_clr;
    logic [DATA_W-1:0] data_out;
    logic              frame_done;
    logic              parity_ok;
    logic              parity_err;
    logic [CNT_W-1:0]  err_count;
    logic              busy;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic              m_in_frame;
    logic              m_q[$];
    logic              m_mode;
    logic [DATA_W-1:0] exp_data;
    logic              exp_done;
    logic              exp_ok;
    logic              exp_err;
    int                exp_cnt;
    logic              exp_busy;

    parity_frame_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .sof        (sof),
        .mode       (mode),
        .err_clr    (err_clr),
        .data_out   (data_out),
        .frame_done (frame_done),
        .parity_ok  (parity_ok),
        .parity_err (parity_err),
        .err_count  (err_count),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at time %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        m_in_frame = 1'b0;
        m_q.delete();
        m_mode   = 1'b0;
        exp_data = '0;
        exp_done = 1'b0;
        exp_ok   = 1'b0;
        exp_err  = 1'b0;
        exp_cnt  = 0;
        exp_busy = 1'b0;
    endtask

    // Frame-level model: collect bits, judge with a popcount on the parity bit.
    task automatic model_step(input logic v, input logic b, input logic s,
                              input logic m, input logic c);
        int   ones;
        logic fail_evt;
        fail_evt = 1'b0;
        exp_done = 1'b0;
        if (v) begin
            if (s) begin
                m_q.delete();
                m_q.push_back(b);
                m_in_frame = 1'b1;
                m_mode     = m;
            end else if (m_in_frame) begin
                if (m_q.size() < DATA_W) begin
                    m_q.push_back(b);
                end else begin
                    ones = int'(b);
                    for (int i = 0; i < DATA_W; i++) begin
                        ones += int'(m_q[i]);
                        exp_data[i] = m_q[i];
                    end
                    exp_ok     = ((ones % 2) == int'(m_mode));
                    exp_err    = !exp_ok;
                    exp_done   = 1'b1;
                    fail_evt   = !exp_ok;
                    m_in_frame = 1'b0;
                    m_q.delete();
                end
            end
        end
        if (fail_evt) exp_cnt = c ? 1 : ((exp_cnt == CNT_MAX) ? CNT_MAX : exp_cnt + 1);
        else if (c) exp_cnt = 0;
        exp_busy = m_in_frame;
    endtask

    // Drive one cycle of inputs, advance the model on the edge, sample at +1.
    task automatic cycle(input logic v, input logic b, input logic s,
                         input logic m, input logic c);
        bit_valid = v;
        bit_in    = b;
        sof       = s;
        mode      = m;
        err_clr   = c;
        @(posedge clk);
        model_step(v, b, s, m, c);
        #1;
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input logic p,
                              input logic m, input logic clr_on_parity);
        for (int k = 0; k < DATA_W; k++) cycle(1'b1, d[k], (k == 0), m, 1'b0);
        cycle(1'b1, p, 1'b0, m, clr_on_parity);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bit_valid = 1'b0; bit_in = 1'b0; sof = 1'b0; mode = 1'b0; err_clr = 1'b0;
        model_reset();
        #12;
        total++;
        if ({data_out, frame_done, parity_ok, parity_err, err_count, busy} !== '0) begin
            bad++;
            $display("FAIL reset_state: got data=%b done=%b ok=%b err=%b cnt=%0d busy=%b want all 0",
                     data_out, frame_done, parity_ok, parity_err, err_count, busy);
        end
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_even_pass();
        send_frame(3'b101, 1'b0, 1'b0, 1'b0);
        total++;
        if ({frame_done, data_out, parity_ok, parity_err, err_count, busy} !== {1'b1, 3'b101, 1'b1, 1'b0, 2'd0, 1'b0}) begin
            bad++;
            $display("FAIL even_pass: got done=%b data=%b ok=%b err=%b cnt=%0d busy=%b want 1 101 1 0 0 0",
                     frame_done, data_out, parity_ok, parity_err, err_count, busy);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if ({frame_done, parity_ok} !== 2'b01) begin
            bad++;
            $display("FAIL done_pulse_width: got done=%b ok=%b want 0 1", frame_done, parity_ok);
        end
    endtask

    task automatic test_even_fail_odd_pass();
        send_frame(3'b101, 1'b1, 1'b0, 1'b0);
        total++;
        if ({frame_done, parity_ok, parity_err, err_count} !== {1'b1, 1'b0, 1'b1, 2'd1}) begin
            bad++;
            $display("FAIL even_fail: got done=%b ok=%b err=%b cnt=%0d want 1 0 1 1",
                     frame_done, parity_ok, parity_err, err_count);
        end
        send_frame(3'b110, 1'b1, 1'b1, 1'b0);
        total++;
        if ({frame_done, data_out, parity_ok, parity_err, err_count} !== {1'b1, 3'b110, 1'b1, 1'b0, 2'd1}) begin
            bad++;
            $display("FAIL odd_pass: got done=%b data=%b ok=%b err=%b cnt=%0d want 1 110 1 0 1",
                     frame_done, data_out, parity_ok, parity_err, err_count);
        end
    endtask

    task automatic test_stalls_mode_hold();
        logic [3:0] bits;
        int busy_bad;
        bits = 4'b0101; // data 1,0,1 then parity 0 (index 3)
        busy_bad = 0;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, bits[k], (k == 0), (k == 0) ? 1'b0 : 1'b1, 1'b0);
            if (k < 3) begin
                if (busy !== 1'b1) busy_bad++;
                for (int g = 0; g < 3; g++) begin
                    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
                    if (busy !== 1'b1 || frame_done !== 1'b0) busy_bad++;
                end
            end
        end
        total++;
        if (busy_bad != 0) begin
            bad++;
            $display("FAIL stall_busy: got %0d cycles with busy low or early done, want 0", busy_bad);
        end
        total++;
        if ({frame_done, data_out, parity_ok, parity_err, busy} !== {1'b1, 3'b101, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL stall_result: got done=%b data=%b ok=%b err=%b busy=%b want 1 101 1 0 0",
                     frame_done, data_out, parity_ok, parity_err, busy);
        end
    endtask

    task automatic test_abort();
        int dones;
        dones = 0;
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); dones += int'(frame_done);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); dones += int'(frame_done);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); dones += int'(frame_done);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); dones += int'(frame_done);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); dones += int'(frame_done);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); dones += int'(frame_done);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); dones += int'(frame_done);
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL abort_done_count: got %0d frame_done pulses want 1", dones);
        end
        total++;
        if ({data_out, parity_ok, parity_err} !== {3'b100, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL abort_result: got data=%b ok=%b err=%b want 100 1 0", data_out, parity_ok, parity_err);
        end
    endtask

    task automatic test_saturation_clear();
        logic [CNT_W-1:0] want[4];
        want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd3;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (err_count !== 2'd0) begin
            bad++;
            $display("FAIL clr_before_sat: got %0d want 0", err_count);
        end
        for (int n = 0; n < 4; n++) begin
            send_frame(3'b101, 1'b1, 1'b0, 1'b0);
            total++;
            if (err_count !== want[n]) begin
                bad++;
                $display("FAIL sat_count_%0d: got %0d want %0d", n, err_count, want[n]);
            end
        end
        send_frame(3'b101, 1'b1, 1'b0, 1'b1);
        total++;
        if ({err_count, parity_err, frame_done} !== {2'd1, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL clr_with_fail: got cnt=%0d err=%b done=%b want 1 1 1", err_count, parity_err, frame_done);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if ({err_count, parity_err} !== {2'd0, 1'b1}) begin
            bad++;
            $display("FAIL clr_alone: got cnt=%0d err=%b want 0 1", err_count, parity_err);
        end
    endtask

    task automatic test_reset_mid_frame();
        int early;
        send_frame(3'b101, 1'b1, 1'b0, 1'b0); // leaves nonzero outputs
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if ({data_out, frame_done, parity_ok, parity_err, err_count, busy} !== '0) begin
            bad++;
            $display("FAIL reset_mid_frame: got data=%b done=%b ok=%b err=%b cnt=%0d busy=%b want all 0",
                     data_out, frame_done, parity_ok, parity_err, err_count, busy);
        end
        #2 rst_n = 1'b1;
        early = 0;
        for (int k = 0; k < DATA_W; k++) begin
            cycle(1'b1, k[0] ? 1'b0 : 1'b1, (k == 0), 1'b0, 1'b0);
            early += int'(frame_done);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (early != 0 || {frame_done, data_out, parity_ok, err_count} !== {1'b1, 3'b101, 1'b1, 2'd0}) begin
            bad++;
            $display("FAIL after_reset_frame: got early=%0d done=%b data=%b ok=%b cnt=%0d want 0 1 101 1 0",
                     early, frame_done, data_out, parity_ok, err_count);
        end
    endtask

    task automatic test_random();
        logic v, s;
        for (int n = 0; n < 600; n++) begin
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 7) == 0);
            cycle(v, 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0));
            total++;
            if (frame_done !== exp_done) begin
                bad++;
                $display("FAIL rand_done[%0d]: got %b want %b", n, frame_done, exp_done);
            end
            total++;
            if (data_out !== exp_data) begin
                bad++;
                $display("FAIL rand_data[%0d]: got %b want %b", n, data_out, exp_data);
            end
            total++;
            if ({parity_ok, parity_err} !== {exp_ok, exp_err}) begin
                bad++;
                $display("FAIL rand_flags[%0d]: got ok=%b err=%b want ok=%b err=%b",
                         n, parity_ok, parity_err, exp_ok, exp_err);
            end
            total++;
            if (err_count !== CNT_W'(exp_cnt)) begin
                bad++;
                $display("FAIL rand_cnt[%0d]: got %0d want %0d", n, err_count, exp_cnt);
            end
            total++;
            if (busy !== exp_busy) begin
                bad++;
                $display("FAIL rand_busy[%0d]: got %b want %b", n, busy, exp_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_even_pass();
        test_even_fail_odd_pass();
        test_stalls_mode_hold();
        test_abort();
        test_saturation_clear();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
